// File: rtl/register_file_scb.sv
// register_file_scb
// Parametrised register file with two write ports, a per-register busy
// scoreboard and PC auto-increment. The last register is the PC.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle write data (and the
// resulting busy state) to the read ports.
module register_file_scb #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 4,
    parameter int PC_RD_OFS = 8,
    parameter int PC_STEP   = 4
) (
    input  logic              CLK,
    input  logic              CLR,
    input  logic              wrEnA,
    input  logic [ADDR_W-1:0] wrAddrA,
    input  logic [DATA_W-1:0] wrDataA,
    input  logic              wrEnB,
    input  logic [ADDR_W-1:0] wrAddrB,
    input  logic [DATA_W-1:0] wrDataB,
    input  logic              rsvEn,
    input  logic [ADDR_W-1:0] rsvAddr,
    input  logic              pcIncEn,
    input  logic [ADDR_W-1:0] addressA,
    input  logic [ADDR_W-1:0] addressB,
    output logic [DATA_W-1:0] outA,
    output logic [DATA_W-1:0] outB,
    output logic              busyA,
    output logic              busyB
);

    localparam int                NREGS   = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] PC_IDX  = ADDR_W'(NREGS - 1);
    localparam logic [DATA_W-1:0] PC_MASK = ~DATA_W'(3);
    localparam logic [DATA_W-1:0] RD_OFS  = DATA_W'(PC_RD_OFS);
    localparam logic [DATA_W-1:0] STEP    = DATA_W'(PC_STEP);

    logic [DATA_W-1:0] regs     [NREGS];
    logic [DATA_W-1:0] regsNext [NREGS];
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busyNext;
    logic [NREGS-1:0]  hitA;
    logic [NREGS-1:0]  hitB;
    logic [NREGS-1:0]  hitR;

    // Enables are qualified with CLR so nothing is forwarded while clearing.
    logic wrA;
    logic wrB;
    logic rsv;
    assign wrA = wrEnA & CLR;
    assign wrB = wrEnB & CLR;
    assign rsv = rsvEn & CLR;

    // One-hot decode of write and reserve targets.
    always_comb begin
        hitA = '0;
        hitB = '0;
        hitR = '0;
        for (int i = 0; i < NREGS; i++) begin
            hitA[i] = wrA && (wrAddrA == ADDR_W'(i));
            hitB[i] = wrB && (wrAddrB == ADDR_W'(i));
            hitR[i] = rsv && (rsvAddr == ADDR_W'(i));
        end
    end

    // Next register contents: port A beats port B; a PC write beats increment.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regsNext[i] = regs[i];
            if (hitA[i]) begin
                regsNext[i] = wrDataA;
            end else if (hitB[i]) begin
                regsNext[i] = wrDataB;
            end
        end
        if (hitA[PC_IDX] || hitB[PC_IDX]) begin
            regsNext[PC_IDX] = regsNext[PC_IDX] & PC_MASK;
        end else if (pcIncEn) begin
            regsNext[PC_IDX] = regs[PC_IDX] + STEP;
        end
    end

    // Next busy bits: a reserve overrides a same-cycle write clear.
    always_comb begin
        busyNext = busy;
        for (int i = 0; i < NREGS; i++) begin
            if (hitR[i]) begin
                busyNext[i] = 1'b1;
            end else if (hitA[i] || hitB[i]) begin
                busyNext[i] = 1'b0;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge CLK or negedge CLR) begin
        if (!CLR) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= regsNext[i];
            end
            busy <= busyNext;
        end
    end

    // Read port A: stored (or forwarded) data, PC offset applied.
    always_comb begin
        outA  = regs[addressA];
        busyA = busy[addressA];
`ifdef REGFILE_BYPASS_EN
        if (hitA[addressA]) begin
            outA = wrDataA;
        end else if (hitB[addressA]) begin
            outA = wrDataB;
        end
        if (hitA[addressA] || hitB[addressA]) begin
            busyA = hitR[addressA];
        end
`endif
        if (addressA == PC_IDX) begin
            outA = (outA & PC_MASK) + RD_OFS;
        end
    end

    // Read port B: same rules as port A.
    always_comb begin
        outB  = regs[addressB];
        busyB = busy[addressB];
`ifdef REGFILE_BYPASS_EN
        if (hitA[addressB]) begin
            outB = wrDataA;
        end else if (hitB[addressB]) begin
            outB = wrDataB;
        end
        if (hitA[addressB] || hitB[addressB]) begin
            busyB = hitR[addressB];
        end
`endif
        if (addressB == PC_IDX) begin
            outB = (outB & PC_MASK) + RD_OFS;
        end
    end

endmodule

// File: tb/tb_register_file_scb.sv
// Testbench for register_file_scb: directed scenarios plus a randomized run
// checked against an array-based reference model.
module tb_register_file_scb;

    localparam int          PC_RD_OFS = 8;
    localparam int          PC_STEP   = 4;
    localparam logic [3:0]  PC        = 4'd15;

    logic        CLK = 1'b0;
    logic        CLR;
    logic        wrEnA, wrEnB, rsvEn, pcIncEn;
    logic [3:0]  wrAddrA, wrAddrB, rsvAddr, addressA, addressB;
    logic [31:0] wrDataA, wrDataB;
    logic [31:0] outA, outB;
    logic        busyA, busyB;

    logic [31:0] mRegs [16];
    logic        mBusy [16];
    int          checkCount = 0;
    int          passCount  = 0;

    register_file_scb dut (
        .CLK(CLK), .CLR(CLR),
        .wrEnA(wrEnA), .wrAddrA(wrAddrA), .wrDataA(wrDataA),
        .wrEnB(wrEnB), .wrAddrB(wrAddrB), .wrDataB(wrDataB),
        .rsvEn(rsvEn), .rsvAddr(rsvAddr), .pcIncEn(pcIncEn),
        .addressA(addressA), .addressB(addressB),
        .outA(outA), .outB(outB), .busyA(busyA), .busyB(busyB)
    );

    always #5 CLK = ~CLK;

    task automatic modelReset();
        for (int i = 0; i < 16; i++) begin
            mRegs[i] = 32'h0;
            mBusy[i] = 1'b0;
        end
    endtask

    // Expected read value given the model state and current inputs.
    function automatic logic [31:0] expRead(input logic [3:0] a);
        logic [31:0] d;
        d = mRegs[a];
`ifdef REGFILE_BYPASS_EN
        if (CLR && wrEnA && wrAddrA == a) d = wrDataA;
        else if (CLR && wrEnB && wrAddrB == a) d = wrDataB & ((a == PC) ? 32'hFFFF_FFFC : 32'hFFFF_FFFF);
        if (a == PC) d = d & 32'hFFFF_FFFC;
`endif
        if (a == PC) d = d + PC_RD_OFS;
        return d;
    endfunction

    function automatic logic expBusy(input logic [3:0] a);
        logic b;
        b = mBusy[a];
`ifdef REGFILE_BYPASS_EN
        if (CLR && ((wrEnA && wrAddrA == a) || (wrEnB && wrAddrB == a)))
            b = rsvEn && (rsvAddr == a);
`endif
        return b;
    endfunction

    // Advance one clock and update the model from the rules, then return at negedge.
    task automatic applyEdge();
        bit pcWritten;
        @(posedge CLK);
        if (CLR) begin
            pcWritten = (wrEnA && wrAddrA == PC) || (wrEnB && wrAddrB == PC);
            if (pcIncEn && !pcWritten) mRegs[PC] = mRegs[PC] + PC_STEP;
            if (wrEnB) mRegs[wrAddrB] = (wrAddrB == PC) ? (wrDataB & ~32'h3) : wrDataB;
            if (wrEnA) mRegs[wrAddrA] = (wrAddrA == PC) ? (wrDataA & ~32'h3) : wrDataA;
            if (wrEnB) mBusy[wrAddrB] = 1'b0;
            if (wrEnA) mBusy[wrAddrA] = 1'b0;
            if (rsvEn) mBusy[rsvAddr] = 1'b1;
        end
        @(negedge CLK);
    endtask

    task automatic idleInputs();
        wrEnA = 0; wrEnB = 0; rsvEn = 0; pcIncEn = 0;
        wrAddrA = 0; wrAddrB = 0; rsvAddr = 0;
        wrDataA = 0; wrDataB = 0;
    endtask

    task automatic test_reset();
        CLR = 1'b0;
        idleInputs();
        addressA = 4'd3; addressB = PC;
        #1;
        checkCount++;
        if (outA !== 32'h0) $display("FAIL reset_r3: got %h want %h", outA, 32'h0); else passCount++;
        checkCount++;
        if (outB !== 32'h8) $display("FAIL reset_pc: got %h want %h", outB, 32'h8); else passCount++;
        checkCount++;
        if ({busyA, busyB} !== 2'b00) $display("FAIL reset_busy: got %b want 00", {busyA, busyB}); else passCount++;
        for (int i = 0; i < 16; i++) begin
            addressA = 4'(i);
            #1;
            checkCount++;
            if (outA !== ((i == 15) ? 32'h8 : 32'h0))
                $display("FAIL reset_all[%0d]: got %h want %h", i, outA, (i == 15) ? 32'h8 : 32'h0);
            else passCount++;
        end
        @(negedge CLK);
        CLR = 1'b1;
    endtask

    task automatic test_collision();
        wrEnA = 1; wrAddrA = 4'd5; wrDataA = 32'hDEADBEEF;
        wrEnB = 1; wrAddrB = 4'd5; wrDataB = 32'h12345678;
        applyEdge();
        idleInputs();
        addressA = 4'd5; addressB = 4'd5;
        #1;
        checkCount++;
        if (outA !== 32'hDEADBEEF) $display("FAIL collision: got %h want %h", outA, 32'hDEADBEEF); else passCount++;
    endtask

    task automatic test_pc();
        wrEnA = 1; wrAddrA = PC; wrDataA = 32'h00001003;
        applyEdge();
        idleInputs();
        addressA = PC;
        #1;
        checkCount++;
        if (outA !== 32'h00001008) $display("FAIL pc_write: got %h want %h", outA, 32'h00001008); else passCount++;
        pcIncEn = 1;
        applyEdge();
        applyEdge();
        pcIncEn = 0;
        #1;
        checkCount++;
        if (outA !== 32'h00001010) $display("FAIL pc_inc: got %h want %h", outA, 32'h00001010); else passCount++;
        // A PC write overrides a simultaneous increment
        wrEnB = 1; wrAddrB = PC; wrDataB = 32'h00000200; pcIncEn = 1;
        applyEdge();
        idleInputs();
        #1;
        checkCount++;
        if (outA !== 32'h00000208) $display("FAIL pc_override: got %h want %h", outA, 32'h00000208); else passCount++;
    endtask

    task automatic test_pc_wrap();
        wrEnA = 1; wrAddrA = PC; wrDataA = 32'hFFFFFFFC;
        applyEdge();
        idleInputs();
        addressA = PC;
        #1;
        checkCount++;
        if (outA !== 32'h00000004) $display("FAIL pc_read_wrap: got %h want %h", outA, 32'h00000004); else passCount++;
        pcIncEn = 1;
        applyEdge();
        pcIncEn = 0;
        #1;
        checkCount++;
        if (outA !== 32'h00000008) $display("FAIL pc_inc_wrap: got %h want %h", outA, 32'h00000008); else passCount++;
    endtask

    task automatic test_scoreboard();
        addressA = 4'd2; addressB = 4'd2;
        rsvEn = 1; rsvAddr = 4'd2;
        applyEdge();
        idleInputs();
        #1;
        checkCount++;
        if (busyA !== 1'b1) $display("FAIL rsv_set: got %b want 1", busyA); else passCount++;
        wrEnB = 1; wrAddrB = 4'd2; wrDataB = 32'h0000_0042;
        rsvEn = 1; rsvAddr = 4'd2;
        #1;
        checkCount++;
        if (busyB !== 1'b1) $display("FAIL rsv_write_same_cycle: got %b want 1", busyB); else passCount++;
        applyEdge();
        idleInputs();
        #1;
        checkCount++;
        if (busyA !== 1'b1) $display("FAIL rsv_beats_write: got %b want 1", busyA); else passCount++;
        wrEnA = 1; wrAddrA = 4'd2; wrDataA = 32'h0000_0077;
        applyEdge();
        idleInputs();
        #1;
        checkCount++;
        if (busyA !== 1'b0) $display("FAIL write_clears: got %b want 0", busyA); else passCount++;
        checkCount++;
        if (outA !== 32'h0000_0077) $display("FAIL sb_data: got %h want %h", outA, 32'h77); else passCount++;
    endtask

    task automatic test_bypass();
        logic [31:0] want;
        wrEnA = 1; wrAddrA = 4'd7; wrDataA = 32'h11111111;
        applyEdge();
        wrDataA = 32'hA5A5A5A5;
        addressA = 4'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        want = 32'hA5A5A5A5;
`else
        want = 32'h11111111;
`endif
        checkCount++;
        if (outA !== want) $display("FAIL bypass_same_cycle: got %h want %h", outA, want); else passCount++;
        applyEdge();
        idleInputs();
        #1;
        checkCount++;
        if (outA !== 32'hA5A5A5A5) $display("FAIL bypass_next_cycle: got %h want %h", outA, 32'hA5A5A5A5); else passCount++;
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            wrEnA = 1'($urandom_range(0, 1)); wrAddrA = 4'($urandom); wrDataA = $urandom;
            wrEnB = 1'($urandom_range(0, 1)); wrAddrB = 4'($urandom); wrDataB = $urandom;
            if ($urandom_range(0, 3) == 0) wrAddrB = wrAddrA;
            rsvEn = 1'($urandom_range(0, 1)); rsvAddr = 4'($urandom);
            pcIncEn = 1'($urandom_range(0, 1));
            addressA = 4'($urandom); addressB = 4'($urandom);
            if ($urandom_range(0, 3) == 0) addressA = wrAddrA;
            if ($urandom_range(0, 3) == 0) addressB = PC;
            #1;
            checkCount++;
            if (outA !== expRead(addressA)) $display("FAIL rand_outA[%0d] addr %0d: got %h want %h", n, addressA, outA, expRead(addressA)); else passCount++;
            checkCount++;
            if (outB !== expRead(addressB)) $display("FAIL rand_outB[%0d] addr %0d: got %h want %h", n, addressB, outB, expRead(addressB)); else passCount++;
            checkCount++;
            if (busyA !== expBusy(addressA)) $display("FAIL rand_busyA[%0d] addr %0d: got %b want %b", n, addressA, busyA, expBusy(addressA)); else passCount++;
            checkCount++;
            if (busyB !== expBusy(addressB)) $display("FAIL rand_busyB[%0d] addr %0d: got %b want %b", n, addressB, busyB, expBusy(addressB)); else passCount++;
            applyEdge();
        end
        idleInputs();
    endtask

    task automatic test_async_reset();
        wrEnA = 1; wrAddrA = 4'd4; wrDataA = 32'h00000055;
        rsvEn = 1; rsvAddr = 4'd9;
        applyEdge();
        idleInputs();
        addressA = 4'd4; addressB = 4'd9;
        #1;
        checkCount++;
        if (outA !== 32'h55 || busyB !== 1'b1) $display("FAIL pre_reset: got %h/%b want 00000055/1", outA, busyB); else passCount++;
        wrEnA = 1; wrAddrA = 4'd4; wrDataA = 32'h0000_0099;
        rsvEn = 1; rsvAddr = 4'd4;
        #1;
        CLR = 1'b0;
        modelReset();
        #1;
        checkCount++;
        if (outA !== 32'h0 || busyA !== 1'b0 || busyB !== 1'b0)
            $display("FAIL async_clear: got %h/%b/%b want 00000000/0/0", outA, busyA, busyB);
        else passCount++;
        applyEdge();
        CLR = 1'b1;
        idleInputs();
        #1;
        checkCount++;
        if (outA !== 32'h0 || busyA !== 1'b0) $display("FAIL write_lost: got %h/%b want 00000000/0", outA, busyA); else passCount++;
        addressB = PC;
        #1;
        checkCount++;
        if (outB !== 32'h8) $display("FAIL pc_after_reset: got %h want %h", outB, 32'h8); else passCount++;
    endtask

    initial begin
        CLR = 1'b0;
        idleInputs();
        addressA = 0; addressB = 0;
        modelReset();
        @(negedge CLK);
        test_reset();
        test_collision();
        test_pc();
        test_pc_wrap();
        test_scoreboard();
        test_bypass();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
